score_sched: RTL and testbench

SCORE_SCHED -- requirements
Module: score_sched

---
 rtl/score_sched.sv | 137 +++++++++++++
 tb/tb_score_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_sched.sv
// score_sched: two-requester score keeper with a shared display output.
// Each requester adds 0..3 points to its own score, which saturates at MAXV.
// A three-state FSM (IDLE -> ADD -> ACK) serves one request at a time.
// Simultaneous requests are granted round-robin, with A served first after reset.
// A free-running dwell counter alternates the shared display between the two scores.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_a, pts_a, ack_a requester A: request, points (0..3), one-cycle done pulse
//   req_b, pts_b, ack_b requester B: same as A
//   clr                 synchronous clear of both scores
//   score_a, score_b    current scores (0..MAXV)
//   disp_val, sel_b     display value and which score it currently shows (1 = B)
//   sat_a, sat_b        score equals MAXV
//   busy                FSM not in IDLE
module score_sched #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned MAXV  = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic [1:0] pts_a,
   output logic       ack_a,
   input  logic       req_b,
   input  logic [1:0] pts_b,
   output logic       ack_b,
   input  logic       clr,
   output logic [6:0] score_a,
   output logic [6:0] score_b,
   output logic [6:0] disp_val,
   output logic       sel_b,
   output logic       sat_a,
   output logic       sat_b,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, ADD, ACK} state_t;

   localparam logic [6:0] MAX7    = 7'(MAXV);
   localparam logic [7:0] DW_LAST = 8'(DWELL - 1);

   state_t     state_q, state_d;
   logic       win_b_q, win_b_d;    // winner of the current transaction is B
   logic       last_b_q, last_b_d;  // B was granted most recently
   logic [1:0] pts_q, pts_d;
   logic [6:0] score_a_q, score_a_d;
   logic [6:0] score_b_q, score_b_d;
   logic [7:0] dwell_q, dwell_d;
   logic       sel_b_q, sel_b_d;

   logic       grant_b;
   logic [7:0] sum;
   logic [6:0] add_res;

   always_comb begin
      state_d   = state_q;
      win_b_d   = win_b_q;
      last_b_d  = last_b_q;
      pts_d     = pts_q;
      score_a_d = score_a_q;
      score_b_d = score_b_q;
      grant_b   = 1'b0;

      // 8-bit sum so that 99 + 3 cannot wrap before the saturation compare
      sum     = {1'b0, (win_b_q ? score_b_q : score_a_q)} + {6'b0, pts_q};
      add_res = (sum > {1'b0, MAX7}) ? MAX7 : sum[6:0];

      case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               // B wins when it is alone, or when both request and A was granted last
               grant_b  = req_b && (!req_a || !last_b_q);
               win_b_d  = grant_b;
               last_b_d = grant_b;
               pts_d    = grant_b ? pts_b : pts_a;
               state_d  = ADD;
            end
         end
         ADD: begin
            if (win_b_q) score_b_d = add_res;
            else         score_a_d = add_res;
            state_d = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // clear overrides a coincident ADD write; the FSM itself is unaffected
      if (clr) begin
         score_a_d = '0;
         score_b_d = '0;
      end
   end

   always_comb begin
      dwell_d = dwell_q + 8'd1;
      sel_b_d = sel_b_q;
      if (dwell_q >= DW_LAST) begin
         dwell_d = '0;
         sel_b_d = !sel_b_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         win_b_q   <= 1'b0;
         last_b_q  <= 1'b1;  // B counts as last granted, so A wins the first tie
         pts_q     <= '0;
         score_a_q <= '0;
         score_b_q <= '0;
         dwell_q   <= '0;
         sel_b_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_b_q   <= win_b_d;
         last_b_q  <= last_b_d;
         pts_q     <= pts_d;
         score_a_q <= score_a_d;
         score_b_q <= score_b_d;
         dwell_q   <= dwell_d;
         sel_b_q   <= sel_b_d;
      end
   end

   assign ack_a    = (state_q == ACK) && !win_b_q;
   assign ack_b    = (state_q == ACK) &&  win_b_q;
   assign busy     = (state_q != IDLE);
   assign score_a  = score_a_q;
   assign score_b  = score_b_q;
   assign sel_b    = sel_b_q;
   assign disp_val = sel_b_q ? score_b_q : score_a_q;
   assign sat_a    = (score_a_q == MAX7);
   assign sat_b    = (score_b_q == MAX7);

endmodule

// File: tb/tb_score_sched.sv
// Directed testbench for score_sched (DWELL = 4, MAXV = 99).
module tb_score_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0, clr = 1'b0;
   logic [1:0] pts_a = '0, pts_b = '0;
   logic       ack_a, ack_b, sel_b, sat_a, sat_b, busy;
   logic [6:0] score_a, score_b, disp_val;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // edges since the last reset release

   score_sched #(.DWELL(4), .MAXV(99)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .pts_a(pts_a), .ack_a(ack_a),
      .req_b(req_b), .pts_b(pts_b), .ack_b(ack_b),
      .clr(clr),
      .score_a(score_a), .score_b(score_b), .disp_val(disp_val),
      .sel_b(sel_b), .sat_a(sat_a), .sat_b(sat_b), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_a = 1'b0; req_b = 1'b0; clr = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   // Runs one transaction; returns in the ACK cycle with req already dropped.
   task automatic do_add(input logic is_b, input logic [1:0] p);
      bit seen = 0;
      if (is_b) begin req_b = 1'b1; pts_b = p; end
      else      begin req_a = 1'b1; pts_a = p; end
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if ((is_b && ack_b) || (!is_b && ack_a)) seen = 1;
      end
      req_a = 1'b0; req_b = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL add_timeout: got no ack, expected ack within 10 cycles (is_b=%0d)", is_b);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, ack_a, ack_b, sel_b} !== 4'b0000 || score_a !== 7'd0 || score_b !== 7'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b ack=%b%b sel=%b sa=%0d sb=%0d, expected all 0",
                  busy, ack_a, ack_b, sel_b, score_a, score_b);
      end
      tick();
      rst = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (sel_b !== (i == 4)) begin
            errors++;
            $display("FAIL reset_dwell_phase: edge %0d got sel_b=%b expected %b", i, sel_b, i == 4);
         end
      end
   endtask

   task automatic test_single_add();
      do_reset();
      req_a = 1'b1; pts_a = 2'd3;
      tick();
      req_a = 1'b0;
      checks++;
      if (busy !== 1'b1 || ack_a !== 1'b0) begin
         errors++;
         $display("FAIL single_add_cycle: got busy=%b ack_a=%b expected busy=1 ack_a=0", busy, ack_a);
      end
      tick();
      checks++;
      if (ack_a !== 1'b1 || ack_b !== 1'b0 || score_a !== 7'd3 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_ack_cycle: got ack_a=%b ack_b=%b score_a=%0d busy=%b expected 1 0 3 1",
                  ack_a, ack_b, score_a, busy);
      end
      tick();
      checks++;
      if (ack_a !== 1'b0 || busy !== 1'b0 || score_a !== 7'd3) begin
         errors++;
         $display("FAIL single_idle: got ack_a=%b busy=%b score_a=%0d expected 0 0 3", ack_a, busy, score_a);
      end
      // zero-point request still completes and leaves the score alone
      do_add(1'b0, 2'd0);
      checks++;
      if (score_a !== 7'd3) begin
         errors++;
         $display("FAIL zero_pts: got score_a=%0d expected 3", score_a);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [6:0] exp_a, exp_b;
      do_reset();
      exp_a = 7'd0; exp_b = 7'd0;
      req_a = 1'b1; pts_a = 2'd1;
      req_b = 1'b1; pts_b = 2'd2;
      for (int g = 0; g < 4; g++) begin
         tick();
         tick();
         if (g % 2 == 0) exp_a = exp_a + 7'd1;
         else            exp_b = exp_b + 7'd2;
         checks++;
         if (ack_a !== (g % 2 == 0) || ack_b !== (g % 2 == 1) || score_a !== exp_a || score_b !== exp_b) begin
            errors++;
            $display("FAIL contention_grant%0d: got ack_a=%b ack_b=%b sa=%0d sb=%0d expected %b %b %0d %0d",
                     g, ack_a, ack_b, score_a, score_b, g % 2 == 0, g % 2 == 1, exp_a, exp_b);
         end
         tick();
         checks++;
         if (ack_a !== 1'b0 || ack_b !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_gap%0d: got ack=%b%b busy=%b expected 0 0 0", g, ack_a, ack_b, busy);
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_a = 1'b1; pts_a = 2'd1;
      tick();                       // ADD for A
      req_b = 1'b1; pts_b = 2'd3;   // B arrives while busy
      tick();                       // ACK for A
      req_a = 1'b0;
      checks++;
      if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
         errors++;
         $display("FAIL b2b_a_ack: got ack_a=%b ack_b=%b expected 1 0", ack_a, ack_b);
      end
      tick();                       // IDLE, samples B
      tick();                       // ADD for B
      checks++;
      if (ack_b !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_b_wait: got ack_b=%b busy=%b expected 0 1", ack_b, busy);
      end
      tick();                       // ACK for B
      req_b = 1'b0;
      checks++;
      if (ack_b !== 1'b1 || score_b !== 7'd3 || score_a !== 7'd1) begin
         errors++;
         $display("FAIL b2b_b_ack: got ack_b=%b sb=%0d sa=%0d expected 1 3 1", ack_b, score_b, score_a);
      end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 32; i++) do_add(1'b1, 2'd3);
      do_add(1'b1, 2'd2);
      checks++;
      if (score_b !== 7'd98 || sat_b !== 1'b0) begin
         errors++;
         $display("FAIL sat_98: got sb=%0d sat_b=%b expected 98 0", score_b, sat_b);
      end
      do_add(1'b1, 2'd3);
      checks++;
      if (score_b !== 7'd99 || sat_b !== 1'b1 || sat_a !== 1'b0) begin
         errors++;
         $display("FAIL sat_99: got sb=%0d sat_b=%b sat_a=%b expected 99 1 0", score_b, sat_b, sat_a);
      end
      do_add(1'b1, 2'd1);
      checks++;
      if (score_b !== 7'd99 || sat_b !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold: got sb=%0d sat_b=%b expected 99 1", score_b, sat_b);
      end
      tick();
   endtask

   task automatic test_clear_collision();
      do_reset();
      do_add(1'b0, 2'd3);
      do_add(1'b1, 2'd2);
      tick();
      req_a = 1'b1; pts_a = 2'd2;
      tick();                       // ADD cycle
      clr = 1'b1;
      tick();                       // ACK cycle
      clr = 1'b0;
      req_a = 1'b0;
      checks++;
      if (ack_a !== 1'b1 || score_a !== 7'd0 || score_b !== 7'd0) begin
         errors++;
         $display("FAIL clr_collision: got ack_a=%b sa=%0d sb=%0d expected 1 0 0", ack_a, score_a, score_b);
      end
      tick();
   endtask

   task automatic test_display();
      logic       exp_sel;
      logic [6:0] exp_disp;
      do_reset();
      for (int i = 0; i < 14; i++) do_add(1'b0, 2'd3);
      do_add(1'b1, 2'd3);
      do_add(1'b1, 2'd3);
      do_add(1'b1, 2'd1);
      for (int i = 0; i < 12; i++) begin
         tick();
         exp_sel  = ((cyc / 4) % 2) == 1;
         exp_disp = exp_sel ? 7'b0000111 : 7'b0101010;
         checks++;
         if (sel_b !== exp_sel || disp_val !== exp_disp) begin
            errors++;
            $display("FAIL display_cyc%0d: got sel_b=%b disp=%b expected %b %b",
                     cyc, sel_b, disp_val, exp_sel, exp_disp);
         end
      end
   endtask

   task automatic test_reset_in_add();
      do_reset();
      do_add(1'b0, 2'd3);
      tick();
      req_b = 1'b1; pts_b = 2'd2;
      tick();                       // ADD cycle
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || ack_b !== 1'b0 || score_a !== 7'd0 || score_b !== 7'd0) begin
         errors++;
         $display("FAIL rst_in_add: got busy=%b ack_b=%b sa=%0d sb=%0d expected 0 0 0 0",
                  busy, ack_b, score_a, score_b);
      end
      req_b = 1'b0;
      tick();
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ack_a !== 1'b0 || ack_b !== 1'b0 || busy !== 1'b0 || score_b !== 7'd0) begin
            errors++;
            $display("FAIL rst_after%0d: got ack=%b%b busy=%b sb=%0d expected 0 0 0 0",
                     i, ack_a, ack_b, busy, score_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_contention();
      test_back_to_back();
      test_saturation();
      test_clear_collision();
      test_display();
      test_reset_in_add();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
